guess_checker: RTL and testbench
================================

GUESS_CHECKER -- requirements
Module: guess_checker

Interface
REQ-001 Parameter MAX_TRIES, default 4, range 1..15: guesses allowed per game when the limit feature is compiled in.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  game enable; when 0, new_game and guess presses are ignored and state holds.
REQ-005 new_game  input  1  active-high; starts a game and latches secret.
REQ-006 secret  input  4  number from the upstream random generator q output.
REQ-007 guess  input  4  player guess from switches.
REQ-008 bt_n  input  1  active-low guess button, already debounced.
REQ-009 higher  output  1  last guess below secret.
REQ-010 lower  output  1  last guess above secret.
REQ-011 match  output  1  last guess equal to secret.
REQ-012 tries  output  4  guesses taken in current game.
REQ-013 game_over  output  1  game in WIN or LOSE state.
REQ-014 win  output  1  game ended by a match.

Function
REQ-015 The FSM SHALL have states IDLE, PLAY, WIN, LOSE, all registered.
REQ-016 A press SHALL be a cycle with bt_n=0 whose previous sampled bt_n was 1; a held button SHALL count as exactly one press.
REQ-017 In any state, new_game=1 with enable=1 SHALL latch secret into an internal register, clear tries, higher, lower, match and win, and enter PLAY on the next edge.
REQ-018 new_game SHALL take priority over a press in the same cycle; that press is discarded.
REQ-019 In PLAY, a press with enable=1 SHALL increment tries (saturating at 15) and compare guess to the latched secret (unsigned, 4-bit).
REQ-020 Compare results SHALL be one-hot among higher/lower/match, updated at the press edge and visible the following cycle (1-cycle latency), and held until the next press or new_game.
REQ-021 guess equal to latched secret SHALL set match=1, win=1 and enter WIN.
REQ-022 Changes on secret after latching SHALL have no effect until the next new_game.
REQ-023 In WIN and LOSE, presses SHALL be ignored; outputs hold; game_over=1.
REQ-024 In IDLE, presses SHALL be ignored and game_over=0.
REQ-025 guess values 0 and 15 SHALL compare correctly with no wrap-around (e.g. guess 15, secret 0 gives lower=1).

Reset
REQ-026 reset=1 SHALL override all inputs and set state IDLE, higher=lower=match=0, tries=0, game_over=0, win=0, latched secret=0.
REQ-027 Reset SHALL load the previous-bt_n register with 1 so a button held through reset release does not register a press.
REQ-028 Reset asserted mid-game SHALL abandon the game; a new_game is needed to resume.

Configuration
REQ-029 With macro GUESS_LIMIT_EN defined, a non-matching press that brings tries to MAX_TRIES SHALL enter LOSE with win=0 and that guess's higher/lower flag shown.
REQ-030 A matching guess on the final allowed try SHALL enter WIN, not LOSE.
REQ-031 Without GUESS_LIMIT_EN, LOSE SHALL be unreachable, play SHALL continue until match, and tries SHALL saturate at 15.

Verification
REQ-032 Reset, then new_game with secret=9, guess=3 and one press -> next cycle higher=1, tries=1, state PLAY.
REQ-033 secret=9 latched, then secret changed to 2, guess=9 and press -> match=1, win=1, game_over=1, tries=1.
REQ-034 bt_n held low for 10 cycles in PLAY -> tries increments by exactly 1.
REQ-035 GUESS_LIMIT_EN, MAX_TRIES=4, secret=5, four presses with guess=15 -> lower=1, tries=4, game_over=1, win=0; a fifth press changes nothing.
REQ-036 new_game and a press in the same cycle with enable=1 -> tries=0, flags cleared, PLAY; with enable=0 -> no change.
REQ-037 reset pulse during PLAY with tries=2 and bt_n held low through release -> IDLE, tries=0, and no press counted after new_game until bt_n returns to 1 and falls again.

Source files
------------

// File: rtl/guess_checker.sv
// Number-guessing game checker: latches a secret on new_game, compares button-qualified guesses.
// Optional try limit with LOSE state is compiled in with macro GUESS_LIMIT_EN.
module guess_checker #(
    parameter int MAX_TRIES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       new_game,
    input  logic [3:0] secret,
    input  logic [3:0] guess,
    input  logic       bt_n,
    output logic       higher,
    output logic       lower,
    output logic       match,
    output logic [3:0] tries,
    output logic       game_over,
    output logic       win
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        WIN  = 2'd2,
        LOSE = 2'd3
    } state_t;

    localparam logic [3:0] TRY_LIMIT_C = 4'(MAX_TRIES);

    state_t     state_r, state_n;
    logic [3:0] secret_r, secret_n;
    logic [3:0] tries_r, tries_n;
    logic       higher_r, higher_n;
    logic       lower_r, lower_n;
    logic       match_r, match_n;
    logic       win_r, win_n;
    logic       game_over_r, game_over_n;
    logic       bt_prev_r;
    logic       press_s;
    logic       lose_en_s;
    logic       lose_s;
    logic [3:0] tries_inc_s;

    // Falling edge of the active-low button; a held button yields one press.
    assign press_s     = bt_prev_r & ~bt_n;
    assign tries_inc_s = (tries_r == 4'd15) ? 4'd15 : (tries_r + 4'd1);

`ifdef GUESS_LIMIT_EN
    assign lose_en_s = 1'b1;
`else
    assign lose_en_s = 1'b0;
`endif
    assign lose_s = lose_en_s & (tries_inc_s >= TRY_LIMIT_C);

    // Next-state and next-output logic.
    always_comb begin
        state_n   = state_r;
        secret_n  = secret_r;
        tries_n   = tries_r;
        higher_n  = higher_r;
        lower_n   = lower_r;
        match_n   = match_r;
        win_n     = win_r;
        if (enable && new_game) begin
            // new_game wins over a same-cycle press, which is dropped
            state_n  = PLAY;
            secret_n = secret;
            tries_n  = 4'd0;
            higher_n = 1'b0;
            lower_n  = 1'b0;
            match_n  = 1'b0;
            win_n    = 1'b0;
        end else if (enable && press_s && (state_r == PLAY)) begin
            tries_n  = tries_inc_s;
            higher_n = (guess < secret_r);
            lower_n  = (guess > secret_r);
            match_n  = (guess == secret_r);
            if (guess == secret_r) begin
                win_n   = 1'b1;
                state_n = WIN;
            end else if (lose_s) begin
                state_n = LOSE;
            end else begin
                state_n = PLAY;
            end
        end else begin
            state_n = state_r;
        end
        case (state_n)
            WIN, LOSE: game_over_n = 1'b1;
            default:   game_over_n = 1'b0;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            secret_r    <= 4'd0;
            tries_r     <= 4'd0;
            higher_r    <= 1'b0;
            lower_r     <= 1'b0;
            match_r     <= 1'b0;
            win_r       <= 1'b0;
            game_over_r <= 1'b0;
            bt_prev_r   <= 1'b1;
        end else begin
            state_r     <= state_n;
            secret_r    <= secret_n;
            tries_r     <= tries_n;
            higher_r    <= higher_n;
            lower_r     <= lower_n;
            match_r     <= match_n;
            win_r       <= win_n;
            game_over_r <= game_over_n;
            bt_prev_r   <= bt_n;
        end
    end

    assign higher    = higher_r;
    assign lower     = lower_r;
    assign match     = match_r;
    assign tries     = tries_r;
    assign game_over = game_over_r;
    assign win       = win_r;

endmodule

// File: tb/tb_guess_checker.sv
// Self-checking bench for guess_checker: directed scenarios plus randomized play
// checked against a behavioural game model.
module tb_guess_checker;
    localparam int MAX_TRIES = 4;

    logic       clk = 1'b0;
    logic       reset, enable, new_game, bt_n;
    logic [3:0] secret, guess;
    logic       higher, lower, match, game_over, win;
    logic [3:0] tries;

    int compared = 0;
    int mismatched = 0;

    // behavioural model of the game
    bit m_playing, m_over, m_won, m_h, m_l, m_m, m_prev;
    int m_secret, m_tries;

    guess_checker #(.MAX_TRIES(MAX_TRIES)) dut (
        .clk(clk), .reset(reset), .enable(enable), .new_game(new_game),
        .secret(secret), .guess(guess), .bt_n(bt_n),
        .higher(higher), .lower(lower), .match(match), .tries(tries),
        .game_over(game_over), .win(win)
    );

    always #5 clk = ~clk;

    task automatic model_update();
        bit pressed;
        int g;
        g = int'(guess);
        if (reset) begin
            m_playing = 0; m_over = 0; m_won = 0;
            m_h = 0; m_l = 0; m_m = 0;
            m_secret = 0; m_tries = 0; m_prev = 1;
        end else begin
            pressed = m_prev && !bt_n;
            m_prev  = bt_n;
            if (enable && new_game) begin
                m_playing = 1; m_over = 0; m_won = 0;
                m_h = 0; m_l = 0; m_m = 0;
                m_secret = int'(secret); m_tries = 0;
            end else if (enable && pressed && m_playing) begin
                m_tries = (m_tries + 1 > 15) ? 15 : m_tries + 1;
                m_h = (g < m_secret);
                m_l = (g > m_secret);
                m_m = (g == m_secret);
                if (g == m_secret) begin
                    m_won = 1; m_over = 1; m_playing = 0;
                end
`ifdef GUESS_LIMIT_EN
                else if (m_tries >= MAX_TRIES) begin
                    m_over = 1; m_playing = 0;
                end
`endif
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_update();
        #1;
    endtask

    function automatic logic [8:0] dut_vec();
        return {higher, lower, match, tries, game_over, win};
    endfunction

    function automatic logic [8:0] exp_vec();
        return {m_h, m_l, m_m, 4'(m_tries), m_over, m_won};
    endfunction

    task automatic press_once(input logic [3:0] g);
        guess = g;
        bt_n = 1'b0;
        cyc();
        bt_n = 1'b1;
        cyc();
    endtask

    task automatic start_game(input logic [3:0] s);
        secret = s;
        new_game = 1'b1;
        cyc();
        new_game = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; new_game = 1'b1; bt_n = 1'b0;
        secret = 4'd6; guess = 4'd6;
        cyc(); cyc();
        compared++;
        if (dut_vec() !== 9'd0) begin
            mismatched++;
            $display("FAIL reset_state: got %b expected %b", dut_vec(), 9'd0);
        end
        reset = 1'b0; new_game = 1'b0; bt_n = 1'b1;
        cyc();
        compared++;
        if (dut_vec() !== exp_vec()) begin
            mismatched++;
            $display("FAIL reset_release: got %b expected %b", dut_vec(), exp_vec());
        end
        // presses in IDLE are ignored
        press_once(4'd3);
        compared++;
        if (dut_vec() !== 9'd0) begin
            mismatched++;
            $display("FAIL idle_press: got %b expected %b", dut_vec(), 9'd0);
        end
    endtask

    task automatic test_basic();
        start_game(4'd9);
        press_once(4'd3);
        compared++;
        if (dut_vec() !== {1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL basic_higher: got %b expected %b", dut_vec(), {1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0});
        end
        start_game(4'd9);
        secret = 4'd2;
        press_once(4'd9);
        compared++;
        if (dut_vec() !== {1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b1}) begin
            mismatched++;
            $display("FAIL secret_latched_win: got %b expected %b", dut_vec(), {1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b1});
        end
        press_once(4'd0);
        compared++;
        if (dut_vec() !== exp_vec() || tries !== 4'd1) begin
            mismatched++;
            $display("FAIL win_hold: got %b expected %b", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_hold();
        start_game(4'd7);
        guess = 4'd1;
        bt_n = 1'b0;
        repeat (10) cyc();
        bt_n = 1'b1;
        cyc();
        compared++;
        if (tries !== 4'd1 || higher !== 1'b1 || dut_vec() !== exp_vec()) begin
            mismatched++;
            $display("FAIL held_button: got %b expected tries=1 higher=1 model %b", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_priority();
        start_game(4'd8);
        press_once(4'd2);
        new_game = 1'b1; bt_n = 1'b0; guess = 4'd8; secret = 4'd8;
        cyc();
        new_game = 1'b0; bt_n = 1'b1;
        cyc();
        compared++;
        if (dut_vec() !== 9'd0) begin
            mismatched++;
            $display("FAIL newgame_priority: got %b expected %b", dut_vec(), 9'd0);
        end
        press_once(4'd2);
        enable = 1'b0; new_game = 1'b1; bt_n = 1'b0; secret = 4'd3; guess = 4'd3;
        cyc();
        new_game = 1'b0; bt_n = 1'b1;
        cyc();
        enable = 1'b1;
        compared++;
        if (dut_vec() !== {1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL disabled_hold: got %b expected %b", dut_vec(), {1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0});
        end
        press_once(4'd8);
        compared++;
        if (dut_vec() !== {1'b0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b1}) begin
            mismatched++;
            $display("FAIL disabled_secret_kept: got %b expected %b", dut_vec(), {1'b0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b1});
        end
    endtask

    task automatic test_boundary();
        start_game(4'd0);
        press_once(4'd15);
        compared++;
        if (dut_vec() !== {1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL guess15_secret0: got %b expected %b", dut_vec(), {1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0});
        end
        start_game(4'd15);
        press_once(4'd0);
        compared++;
        if (dut_vec() !== {1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL guess0_secret15: got %b expected %b", dut_vec(), {1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0});
        end
        press_once(4'd15);
        compared++;
        if (dut_vec() !== {1'b0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b1}) begin
            mismatched++;
            $display("FAIL guess15_secret15: got %b expected %b", dut_vec(), {1'b0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b1});
        end
    endtask

    task automatic test_reset_mid_game();
        start_game(4'd10);
        press_once(4'd1);
        press_once(4'd1);
        bt_n = 1'b0;
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        cyc();
        compared++;
        if (dut_vec() !== 9'd0) begin
            mismatched++;
            $display("FAIL reset_mid_game: got %b expected %b", dut_vec(), 9'd0);
        end
        start_game(4'd10);
        guess = 4'd10;
        cyc(); cyc();
        compared++;
        if (tries !== 4'd0 || dut_vec() !== exp_vec()) begin
            mismatched++;
            $display("FAIL held_through_reset: got %b expected %b", dut_vec(), exp_vec());
        end
        bt_n = 1'b1;
        cyc();
        bt_n = 1'b0;
        cyc();
        bt_n = 1'b1;
        compared++;
        if (dut_vec() !== {1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b1}) begin
            mismatched++;
            $display("FAIL refall_after_reset: got %b expected %b", dut_vec(), {1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b1});
        end
    endtask

    task automatic test_limit();
`ifdef GUESS_LIMIT_EN
        start_game(4'd5);
        for (int i = 0; i < 5; i++) begin
            press_once(4'd15);
            compared++;
            if (dut_vec() !== exp_vec()) begin
                mismatched++;
                $display("FAIL limit_press%0d: got %b expected %b", i, dut_vec(), exp_vec());
            end
        end
        compared++;
        if (dut_vec() !== {1'b0, 1'b1, 1'b0, 4'(MAX_TRIES), 1'b1, 1'b0}) begin
            mismatched++;
            $display("FAIL limit_lose: got %b expected %b", dut_vec(), {1'b0, 1'b1, 1'b0, 4'(MAX_TRIES), 1'b1, 1'b0});
        end
        start_game(4'd5);
        for (int i = 0; i < MAX_TRIES - 1; i++) press_once(4'd0);
        press_once(4'd5);
        compared++;
        if (dut_vec() !== {1'b0, 1'b0, 1'b1, 4'(MAX_TRIES), 1'b1, 1'b1}) begin
            mismatched++;
            $display("FAIL limit_last_win: got %b expected %b", dut_vec(), {1'b0, 1'b0, 1'b1, 4'(MAX_TRIES), 1'b1, 1'b1});
        end
`else
        start_game(4'd5);
        for (int i = 0; i < 17; i++) press_once(4'd0);
        compared++;
        if (dut_vec() !== {1'b1, 1'b0, 1'b0, 4'd15, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL tries_saturate: got %b expected %b", dut_vec(), {1'b1, 1'b0, 1'b0, 4'd15, 1'b0, 1'b0});
        end
        press_once(4'd5);
        compared++;
        if (dut_vec() !== {1'b0, 1'b0, 1'b1, 4'd15, 1'b1, 1'b1}) begin
            mismatched++;
            $display("FAIL saturated_win: got %b expected %b", dut_vec(), {1'b0, 1'b0, 1'b1, 4'd15, 1'b1, 1'b1});
        end
`endif
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 99) < 2);
            enable   = ($urandom_range(0, 9) != 0);
            new_game = ($urandom_range(0, 24) == 0);
            bt_n     = ($urandom_range(0, 1) == 1);
            secret   = 4'($urandom_range(0, 15));
            guess    = 4'($urandom_range(0, 15));
            cyc();
            compared++;
            if (dut_vec() !== exp_vec()) begin
                mismatched++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_cycle%0d: got %b expected %b", i, dut_vec(), exp_vec());
            end
        end
        reset = 1'b0; enable = 1'b1; new_game = 1'b0; bt_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_priority();
        test_boundary();
        test_reset_mid_game();
        test_limit();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
